// File: rtl/mmio_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// mmio_io_ctrl_if
//   Load/store bus between the core's execute stage and the MMIO controller.
//   master : core side (drives address, store data, byte enables, load strobe)
//   slave  : controller side (returns registered load data)
//   addr   : byte address from the ALU
//   wdata  : store data
//   we     : byte write enables, any bit set marks a write
//   re     : load strobe
//   rdata  : load data, valid the cycle after re
// ---------------------------------------------------------------------------
interface mmio_io_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/mmio_io_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_io_ctrl
//   MMIO controller between the core and the on-chip UART. Decodes a 256-byte
//   window at BASE_ADDR and exposes status, RX/TX FIFOs, cycle and
//   retired-instruction counters. Loads return data one cycle after re,
//   matching the synchronous memories (request in execute, data in writeback).
// Ports
//   clk             : single rising-edge clock
//   rst             : asynchronous active-low reset
//   bus             : load/store bus (slave side)
//   inst_retired_i  : one pulse per retired instruction
//   uart_tx_data_o  : head byte of the TX FIFO
//   uart_tx_valid_o : TX FIFO not empty
//   uart_tx_ready_i : UART accepts the byte this cycle
//   uart_rx_data_i  : byte from the UART receiver
//   uart_rx_valid_i : UART offers a byte
//   uart_rx_ready_o : RX FIFO not full
// ---------------------------------------------------------------------------
module mmio_io_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_io_ctrl_if.slave        bus,
  input  logic                 inst_retired_i,
  output logic [7:0]           uart_tx_data_o,
  output logic                 uart_tx_valid_o,
  input  logic                 uart_tx_ready_i,
  input  logic [7:0]           uart_rx_data_i,
  input  logic                 uart_rx_valid_i,
  output logic                 uart_rx_ready_o
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;

  // Word offsets (addr[7:2]) of the register map.
  localparam logic [5:0] OFF_STATUS  = 6'h00;
  localparam logic [5:0] OFF_RX_DATA = 6'h01;
  localparam logic [5:0] OFF_TX_DATA = 6'h02;
  localparam logic [5:0] OFF_CYCLE   = 6'h04;
  localparam logic [5:0] OFF_INSTRET = 6'h05;
  localparam logic [5:0] OFF_CNT_RST = 6'h06;
  localparam logic [5:0] OFF_LEVELS  = 6'h07;

  // State
  logic [7:0]           tx_mem [TX_DEPTH];
  logic [7:0]           rx_mem [RX_DEPTH];
  logic [TX_AW-1:0]     tx_wr_ptr_q, tx_rd_ptr_q;
  logic [RX_AW-1:0]     rx_wr_ptr_q, rx_rd_ptr_q;
  logic [TX_CW-1:0]     tx_cnt_q;
  logic [RX_CW-1:0]     rx_cnt_q;
  logic                 tx_ovf_q;
  logic [CNT_WIDTH-1:0] cycle_q, instret_q;
  logic [31:0]          rdata_q, rdata_d;

  // Decode
  logic       in_win, wr_en, rd_en;
  logic [5:0] off;
  assign in_win = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign off    = bus.addr[7:2];
  assign wr_en  = in_win && (bus.we != 4'b0000);
  // A write wins over a simultaneous read: the read is dropped entirely, so
  // it neither returns data nor pops the RX FIFO.
  assign rd_en  = in_win && bus.re && !wr_en;

  // FIFO control
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic cnt_clr, ovf_clr;

  assign tx_full     = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign tx_empty    = (tx_cnt_q == '0);
  assign rx_full     = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_empty    = (rx_cnt_q == '0);

  // Fullness is judged on the registered count, so a push into a full FIFO
  // is dropped even if the UART drains an entry on the same edge.
  assign tx_push_req = wr_en && (off == OFF_TX_DATA) && bus.we[0];
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = !tx_empty && uart_tx_ready_i;
  assign rx_push     = uart_rx_valid_i && !rx_full;
  assign rx_pop      = rd_en && (off == OFF_RX_DATA) && !rx_empty;
  assign cnt_clr     = wr_en && (off == OFF_CNT_RST);
  assign ovf_clr     = wr_en && (off == OFF_STATUS) && bus.wdata[2];

  // Read mux
  logic [7:0] tx_lvl, rx_lvl;
  assign tx_lvl = 8'(tx_cnt_q);
  assign rx_lvl = 8'(rx_cnt_q);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (off)
        OFF_STATUS:  rdata_d = {29'b0, tx_ovf_q, !rx_empty, !tx_full};
        OFF_RX_DATA: rdata_d = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rd_ptr_q]};
        OFF_CYCLE:   rdata_d = 32'(cycle_q);
        OFF_INSTRET: rdata_d = 32'(instret_q);
        OFF_LEVELS:  rdata_d = {8'b0, tx_lvl, 8'b0, rx_lvl};
        default:     rdata_d = '0;
      endcase
    end
  end

  // NOTE: the FIFO storage arrays are deliberately not reset; the pointers
  // and counts are, which makes stale contents unreachable and keeps the
  // arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr_q] <= uart_rx_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_ovf_q    <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
      rdata_q     <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_AW'(1);
      tx_cnt_q <= tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);

      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RX_AW'(1);
      rx_cnt_q <= rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);

      if (tx_push_req && tx_full) tx_ovf_q <= 1'b1;
      else if (ovf_clr)           tx_ovf_q <= 1'b0;

      // Clear dominates a same-cycle increment.
      cycle_q   <= cnt_clr ? '0 : cycle_q + CNT_WIDTH'(1);
      instret_q <= cnt_clr ? '0 : instret_q + CNT_WIDTH'(inst_retired_i);

      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata       = rdata_q;
  assign uart_tx_data_o  = tx_mem[tx_rd_ptr_q];
  assign uart_tx_valid_o = !tx_empty;
  assign uart_rx_ready_o = !rx_full;

  // Address byte-lane bits and upper store data have no function here.
  logic unused_bits;
  assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_io_ctrl
//   Directed bench for mmio_io_ctrl. Inputs change on the falling edge, the
//   DUT samples on the rising edge, outputs are checked on the next falling
//   edge. Counters are built 8 bits wide so the wrap is reachable.
// ---------------------------------------------------------------------------
module tb_mmio_io_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic       clk;
  logic       rst;
  logic       inst_retired;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_io_ctrl_if bus ();

  mmio_io_ctrl #(
    .BASE_ADDR (BASE),
    .RX_DEPTH  (8),
    .TX_DEPTH  (8),
    .CNT_WIDTH (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .inst_retired_i  (inst_retired),
    .uart_tx_data_o  (uart_tx_data),
    .uart_tx_valid_o (uart_tx_valid),
    .uart_tx_ready_i (uart_tx_ready),
    .uart_rx_data_i  (uart_rx_data),
    .uart_rx_valid_i (uart_rx_valid),
    .uart_rx_ready_o (uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: called on a falling edge, return on the next one.
  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
    bus.addr = BASE | {24'h0, off}; bus.wdata = d; bus.we = 4'hF; bus.re = 1'b0;
    @(negedge clk);
    bus.we = 4'h0;
  endtask

  task automatic bus_rd(input logic [7:0] off, output logic [31:0] d);
    bus.addr = BASE | {24'h0, off}; bus.we = 4'h0; bus.re = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0; inst_retired = 1'b0; uart_tx_ready = 1'b0;
    uart_rx_data = 8'h0; uart_rx_valid = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.we = '0; bus.re = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", bus.rdata, 32'h0); end
    n_checks++; if (uart_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", uart_rx_ready); end
    n_checks++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", uart_tx_valid); end
    bus_rd(8'h00, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h want %h", rd, 32'h1); end
    bus_rd(8'h1C, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_levels: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_tx_basic();
    uart_tx_ready = 1'b1;
    bus_wr(8'h08, 32'h41);
    n_checks++; if (uart_tx_data !== 8'h41 || uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_first: got %h/%b want 41/1", uart_tx_data, uart_tx_valid); end
    bus_wr(8'h08, 32'h42);
    n_checks++; if (uart_tx_data !== 8'h42 || uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_second: got %h/%b want 42/1", uart_tx_data, uart_tx_valid); end
    @(negedge clk);
    n_checks++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: valid got %b want 0", uart_tx_valid); end
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd;
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_wr(8'h08, 32'h10 + i);
    bus_rd(8'h1C, rd);
    n_checks++; if (rd !== 32'h0008_0000) begin n_fail++; $display("FAIL ovf_levels: got %h want %h", rd, 32'h0008_0000); end
    bus_rd(8'h00, rd);
    n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL ovf_status: got %h want %h", rd, 32'h4); end
    n_checks++; if (uart_tx_data !== 8'h10) begin n_fail++; $display("FAIL ovf_head: got %h want 10", uart_tx_data); end
    bus_wr(8'h00, 32'h4);
    bus_rd(8'h00, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", rd, 32'h0); end
    // Push into a full FIFO on the same edge the UART drains one entry.
    bus.addr = BASE | 32'h08; bus.wdata = 32'h99; bus.we = 4'hF; uart_tx_ready = 1'b1;
    @(negedge clk);
    bus.we = 4'h0; uart_tx_ready = 1'b0;
    bus_rd(8'h00, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL ovf_drain_status: got %h want %h", rd, 32'h5); end
    bus_rd(8'h1C, rd);
    n_checks++; if (rd !== 32'h0007_0000) begin n_fail++; $display("FAIL ovf_drain_levels: got %h want %h", rd, 32'h0007_0000); end
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (uart_tx_data !== 8'(8'h11 + i) || uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_byte%0d: got %h/%b want %h/1", i, uart_tx_data, uart_tx_valid, 8'(8'h11 + i)); end
      @(negedge clk);
    end
    n_checks++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_empty: valid got %b want 0", uart_tx_valid); end
    uart_tx_ready = 1'b0;
    bus_wr(8'h00, 32'h4);
  endtask

  task automatic test_rx();
    logic [31:0] rd;
    uart_rx_data = 8'h55; uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_data = 8'hAA;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    bus_rd(8'h00, rd);
    n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL rx_status: got %h want %h", rd, 32'h3); end
    bus_rd(8'h04, rd);
    n_checks++; if (rd !== 32'h55) begin n_fail++; $display("FAIL rx_pop1: got %h want %h", rd, 32'h55); end
    bus_rd(8'h04, rd);
    n_checks++; if (rd !== 32'hAA) begin n_fail++; $display("FAIL rx_pop2: got %h want %h", rd, 32'hAA); end
    bus_rd(8'h04, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rx_pop_empty: got %h want %h", rd, 32'h0); end
    bus_rd(8'h1C, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rx_levels: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_rx_full();
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) begin
      uart_rx_data = 8'(8'h60 + i); uart_rx_valid = 1'b1;
      @(negedge clk);
    end
    uart_rx_valid = 1'b0;
    n_checks++; if (uart_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rxfull_ready: got %b want 0", uart_rx_ready); end
    bus_rd(8'h1C, rd);
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL rxfull_levels: got %h want %h", rd, 32'h8); end
    // Pop while the UART keeps offering: the push waits for the freed slot.
    uart_rx_data = 8'h70; uart_rx_valid = 1'b1;
    bus_rd(8'h04, rd);
    n_checks++; if (rd !== 32'h60) begin n_fail++; $display("FAIL rxfull_pop: got %h want %h", rd, 32'h60); end
    n_checks++; if (uart_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rxfull_ready_after_pop: got %b want 1", uart_rx_ready); end
    bus_rd(8'h1C, rd);
    uart_rx_valid = 1'b0;
    n_checks++; if (rd !== 32'h7) begin n_fail++; $display("FAIL rxfull_levels_after_pop: got %h want %h", rd, 32'h7); end
    n_checks++; if (uart_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rxfull_refilled: got %b want 0", uart_rx_ready); end
    for (int i = 0; i < 7; i++) begin
      bus_rd(8'h04, rd);
      n_checks++; if (rd !== 32'(8'h61 + i)) begin n_fail++; $display("FAIL rxfull_drain%0d: got %h want %h", i, rd, 32'(8'h61 + i)); end
    end
    bus_rd(8'h04, rd);
    n_checks++; if (rd !== 32'h70) begin n_fail++; $display("FAIL rxfull_last: got %h want %h", rd, 32'h70); end
    bus_rd(8'h00, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL rxfull_status_end: got %h want %h", rd, 32'h1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    // Push and pop on the same edge with one entry held.
    uart_rx_data = 8'h11; uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_data = 8'h22;
    bus_rd(8'h04, rd);
    uart_rx_valid = 1'b0;
    n_checks++; if (rd !== 32'h11) begin n_fail++; $display("FAIL b2b_pop: got %h want %h", rd, 32'h11); end
    bus_rd(8'h1C, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL b2b_levels: got %h want %h", rd, 32'h1); end
    // Read and write together on RX_DATA: write wins, no data, no pop.
    bus.addr = BASE | 32'h04; bus.wdata = 32'h0; bus.we = 4'hF; bus.re = 1'b1;
    @(negedge clk);
    bus.we = 4'h0; bus.re = 1'b0;
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rw_rx_rdata: got %h want %h", bus.rdata, 32'h0); end
    bus_rd(8'h1C, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL rw_rx_nopop: got %h want %h", rd, 32'h1); end
    bus_rd(8'h04, rd);
    n_checks++; if (rd !== 32'h22) begin n_fail++; $display("FAIL b2b_second: got %h want %h", rd, 32'h22); end
    // Read and write together on TX_DATA: push still happens.
    bus.addr = BASE | 32'h08; bus.wdata = 32'h33; bus.we = 4'h1; bus.re = 1'b1;
    @(negedge clk);
    bus.we = 4'h0; bus.re = 1'b0;
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rw_tx_rdata: got %h want %h", bus.rdata, 32'h0); end
    n_checks++; if (uart_tx_data !== 8'h33 || uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL rw_tx_push: got %h/%b want 33/1", uart_tx_data, uart_tx_valid); end
    // Outside the window: read returns 0, write is ignored.
    bus.addr = BASE + 32'h100; bus.re = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL outside_read: got %h want %h", bus.rdata, 32'h0); end
    bus.addr = BASE + 32'h108; bus.wdata = 32'h44; bus.we = 4'hF;
    @(negedge clk);
    bus.we = 4'h0;
    // LEVELS with addr[1:0]=2'b10 must decode as LEVELS.
    bus_rd(8'h1E, rd);
    n_checks++; if (rd !== 32'h0001_0000) begin n_fail++; $display("FAIL outside_write_levels: got %h want %h", rd, 32'h0001_0000); end
    uart_tx_ready = 1'b1;
    @(negedge clk);
    uart_tx_ready = 1'b0;
    n_checks++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tx_empty: got %b want 0", uart_tx_valid); end
  endtask

  task automatic test_counters();
    logic [31:0] rd;
    bus_wr(8'h18, 32'h0);
    for (int k = 1; k <= 100; k++) begin
      inst_retired = (k <= 37);
      @(negedge clk);
    end
    inst_retired = 1'b0;
    bus_rd(8'h10, rd);
    n_checks++; if (rd !== 32'd100) begin n_fail++; $display("FAIL cnt_cycle: got %0d want 100", rd); end
    bus_rd(8'h14, rd);
    n_checks++; if (rd !== 32'd37) begin n_fail++; $display("FAIL cnt_instret: got %0d want 37", rd); end
    // Clear while an instruction retires on the same edge.
    inst_retired = 1'b1;
    bus_wr(8'h18, 32'h0);
    inst_retired = 1'b0;
    bus_rd(8'h10, rd);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL cnt_clr_cycle0: got %0d want 0", rd); end
    bus_rd(8'h10, rd);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL cnt_clr_cycle1: got %0d want 1", rd); end
    bus_rd(8'h14, rd);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL cnt_clr_instret: got %0d want 0", rd); end
    // 8-bit CYCLE runs to 255 and wraps to 0.
    bus_wr(8'h18, 32'h0);
    repeat (255) @(negedge clk);
    bus_rd(8'h10, rd);
    n_checks++; if (rd !== 32'd255) begin n_fail++; $display("FAIL cnt_max: got %0d want 255", rd); end
    bus_rd(8'h10, rd);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap: got %0d want 0", rd); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    uart_tx_ready = 1'b0;
    bus_wr(8'h08, 32'hA1);
    bus_wr(8'h08, 32'hA2);
    bus.addr = BASE; bus.re = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.rdata !== 32'h1) begin n_fail++; $display("FAIL midop_inflight: got %h want %h", bus.rdata, 32'h1); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL midop_rdata: got %h want %h", bus.rdata, 32'h0); end
    n_checks++; if (uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b1) begin n_fail++; $display("FAIL midop_flags: got %b/%b want 0/1", uart_tx_valid, uart_rx_ready); end
    bus.re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_rd(8'h1C, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midop_levels: got %h want %h", rd, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx();
    test_rx_full();
    test_back_to_back();
    test_counters();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
